// File: rtl/if_stage.sv
// if_stage: instruction fetch. Owns the PC, the imem req/ack handshake,
// the IF/ID pipeline register and a one-entry skid buffer that catches a
// fetch completing while the pipeline is stalled.
module if_stage #(
  parameter int unsigned         PC_WIDTH    = 32,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus4,
  output logic                   ifid_valid,
  output logic                   fetch_busy
);

  // BOOT: idle cycle after reset; RUN: fetching at pc; FULL: skid holds a
  // fetched word, no request; DRAIN: waiting out a request made stale by a flush.
  typedef enum logic [1:0] {BOOT, RUN, FULL, DRAIN} state_e;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;
  logic [PC_WIDTH-1:0]    target_q, target_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0]    skid_pc4_q, skid_pc4_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc4_q, ifid_pc4_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    redirect_aligned;

  assign pc_plus4         = pc_q + PC_STEP;
  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  // The request address is the stale drain address while draining so it
  // never moves between request and ack.
  assign imem_req      = (state_q == RUN) || (state_q == DRAIN);
  assign imem_addr     = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign fetch_busy    = ((state_q == RUN) && !imem_ack) || (state_q == DRAIN);
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc4_q;
  assign ifid_valid    = ifid_valid_q;

  // Next-state, PC, skid and IF/ID update; flush has top priority in every
  // state except BOOT, then ack, then stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    target_d     = target_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (flush) begin
          ifid_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = redirect_aligned;
          end else begin
            drain_addr_d = pc_q;
            target_d     = redirect_aligned;
            state_d      = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = FULL;
          end else begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end

      FULL: begin
        if (flush) begin
          skid_instr_d = '0;
          skid_pc4_d   = '0;
          pc_d         = redirect_aligned;
          ifid_valid_d = 1'b0;
          state_d      = RUN;
        end else if (!stall) begin
          ifid_instr_d = skid_instr_q;
          ifid_pc4_d   = skid_pc4_q;
          ifid_valid_d = 1'b1;
          state_d      = RUN;
        end
      end

      DRAIN: begin
        ifid_valid_d = 1'b0;
        if (imem_ack) begin
          pc_d    = flush ? redirect_aligned : target_q;
          state_d = RUN;
        end else if (flush) begin
          target_d = redirect_aligned;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers; an asynchronous reset abandons any outstanding request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      target_q     <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      target_q     <= target_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  // Model: booted flag, pending-redirect (drain) info, a skid queue and IF/ID.
  bit          m_booted;
  bit          m_drain;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_target;
  logic [31:0] m_drain_addr;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [63:0] m_skid[$];

  if_stage #(
    .PC_WIDTH(32),
    .INSTR_WIDTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid),
    .fetch_busy(fetch_busy)
  );

  // Memory responder: every word's content is a fixed function of its address.
  assign imem_rdata = imem_addr ^ KEY;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic a, input logic s, input logic f, input logic [31:0] r);
    imem_ack    = a;
    stall       = s;
    flush       = f;
    redirect_pc = r;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    m_booted     = 1'b0;
    m_drain      = 1'b0;
    m_valid      = 1'b0;
    m_pc         = 32'h0;
    m_target     = 32'h0;
    m_drain_addr = 32'h0;
    m_instr      = 32'h0;
    m_pc4        = 32'h0;
    m_skid.delete();
  endtask

  task automatic model_update();
    logic [31:0] rd;
    rd = redirect_pc & 32'hFFFF_FFFC;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_drain) begin
      if (imem_ack) begin
        m_pc    = flush ? rd : m_target;
        m_drain = 1'b0;
      end else if (flush) begin
        m_target = rd;
      end
    end else if (m_skid.size() != 0) begin
      if (flush) begin
        m_skid.delete();
        m_pc    = rd;
        m_valid = 1'b0;
      end else if (!stall) begin
        {m_instr, m_pc4} = m_skid.pop_front();
        m_valid = 1'b1;
      end
    end else if (flush) begin
      m_valid = 1'b0;
      if (imem_ack) begin
        m_pc = rd;
      end else begin
        m_drain      = 1'b1;
        m_drain_addr = m_pc;
        m_target     = rd;
      end
    end else if (imem_ack) begin
      if (stall) begin
        m_skid.push_back({m_pc ^ KEY, m_pc + 32'd4});
      end else begin
        m_instr = m_pc ^ KEY;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: req=%b valid=%b instr=%h pc4=%h busy=%b, expected all zero", imem_req, ifid_valid, ifid_instr, ifid_pc_plus4, fetch_busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL boot_no_req: req=%b expected 0", imem_req);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL first_fetch: req=%b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    step();
    step();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h8) begin
      errors++;
      $display("[TB] FAIL pre_async_reset: valid=%b pc4=%h expected 1/00000008", ifid_valid, ifid_pc_plus4);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: req=%b valid=%b instr=%h pc4=%h expected all zero", imem_req, ifid_valid, ifid_instr, ifid_pc_plus4);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'(4 * (i + 1)) || ifid_instr !== (32'(4 * i) ^ KEY)) begin
        errors++;
        $display("[TB] FAIL zero_wait[%0d]: valid=%b pc4=%h instr=%h expected 1/%h/%h", i, ifid_valid, ifid_pc_plus4, ifid_instr, 32'(4 * (i + 1)), 32'(4 * i) ^ KEY);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_addr;
    logic        a;
    do_reset();
    step();
    exp_addr = 32'h0;
    for (int c = 0; c < 12; c++) begin
      a = ((c % 3) == 2);
      drive(a, 1'b0, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr || fetch_busy !== !a) begin
        errors++;
        $display("[TB] FAIL wait_req[%0d]: req=%b addr=%h busy=%b expected 1/%h/%b", c, imem_req, imem_addr, fetch_busy, exp_addr, !a);
      end
      step();
      checks++;
      if (ifid_valid !== a || (a && ifid_pc_plus4 !== exp_addr + 32'd4)) begin
        errors++;
        $display("[TB] FAIL wait_ifid[%0d]: valid=%b pc4=%h expected %b/%h", c, ifid_valid, ifid_pc_plus4, a, exp_addr + 32'd4);
      end
      if (a) exp_addr = exp_addr + 32'd4;
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    repeat (4) step();
    checks++;
    if (ifid_pc_plus4 !== 32'h10 || imem_addr !== 32'h10) begin
      errors++;
      $display("[TB] FAIL stall_setup: pc4=%h addr=%h expected 00000010/00000010", ifid_pc_plus4, imem_addr);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h10 || ifid_instr !== (32'h0C ^ KEY) || imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b pc4=%h instr=%h req=%b busy=%b expected 1/00000010/%h/0/0", c, ifid_valid, ifid_pc_plus4, ifid_instr, imem_req, fetch_busy, 32'h0C ^ KEY);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h14 || ifid_instr !== (32'h10 ^ KEY) || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++;
      $display("[TB] FAIL skid_release: valid=%b pc4=%h instr=%h req=%b addr=%h expected 1/00000014/%h/1/00000014", ifid_valid, ifid_pc_plus4, ifid_instr, imem_req, imem_addr, 32'h10 ^ KEY);
    end
    step();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h18 || ifid_instr !== (32'h14 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL after_skid: valid=%b pc4=%h instr=%h expected 1/00000018/%h", ifid_valid, ifid_pc_plus4, ifid_instr, 32'h14 ^ KEY);
    end
  endtask

  task automatic test_flush_drain();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    repeat (8) step();
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_setup: req=%b addr=%h busy=%b expected 1/00000020/1", imem_req, imem_addr, fetch_busy);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      drive(c == 1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL drain[%0d]: valid=%b req=%b addr=%h busy=%b expected 0/1/00000020/1", c, ifid_valid, imem_req, imem_addr, fetch_busy);
      end
    end
    step();
    checks++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("[TB] FAIL drain_done: valid=%b req=%b addr=%h expected 0/1/00000100", ifid_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h104 || ifid_instr !== (32'h100 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL redirect_fetch: valid=%b pc4=%h instr=%h expected 1/00000104/%h", ifid_valid, ifid_pc_plus4, ifid_instr, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_flush_stall_full();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    repeat (2) step();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_no_req: req=%b expected 0", imem_req);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h203);
    step();
    checks++;
    if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("[TB] FAIL full_flush: valid=%b req=%b addr=%h expected 0/1/00000200", ifid_valid, imem_req, imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h204 || ifid_instr !== (32'h200 ^ KEY)) begin
      errors++;
      $display("[TB] FAIL skid_cleared: valid=%b pc4=%h instr=%h expected 1/00000204/%h", ifid_valid, ifid_pc_plus4, ifid_instr, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    checks++;
    if (ifid_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_redirect: valid=%b addr=%h expected 0/fffffffc", ifid_valid, imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h0 || ifid_instr !== (32'hFFFF_FFFC ^ KEY) || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap: valid=%b pc4=%h instr=%h addr=%h expected 1/00000000/%h/00000000", ifid_valid, ifid_pc_plus4, ifid_instr, imem_addr, 32'hFFFF_FFFC ^ KEY);
    end
    step();
    checks++;
    if (ifid_pc_plus4 !== 32'h4 || ifid_instr !== KEY) begin
      errors++;
      $display("[TB] FAIL after_wrap: pc4=%h instr=%h expected 00000004/%h", ifid_pc_plus4, ifid_instr, KEY);
    end
  endtask

  task automatic test_random();
    logic        exp_req;
    logic        exp_busy;
    logic [31:0] exp_addr;
    logic [31:0] rd;
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), rd);
      exp_req  = m_booted && (m_skid.size() == 0);
      exp_addr = m_drain ? m_drain_addr : m_pc;
      exp_busy = m_drain || (exp_req && !imem_ack);
      checks++;
      if (imem_req !== exp_req || fetch_busy !== exp_busy || (exp_req && imem_addr !== exp_addr)) begin
        errors++;
        $display("[TB] FAIL rand_req[%0d]: req=%b busy=%b addr=%h expected %b/%b/%h", c, imem_req, fetch_busy, imem_addr, exp_req, exp_busy, exp_addr);
      end
      model_update();
      step();
      checks++;
      if (ifid_valid !== m_valid || ifid_pc_plus4 !== m_pc4 || ifid_instr !== m_instr) begin
        errors++;
        $display("[TB] FAIL rand_ifid[%0d]: valid=%b pc4=%h instr=%h expected %b/%h/%h", c, ifid_valid, ifid_pc_plus4, ifid_instr, m_valid, m_pc4, m_instr);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    imem_ack    = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_skid();
    test_flush_drain();
    test_flush_stall_full();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the five-stage pipeline, directly upstream of the datapath's ID stage. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It also owns the IF/ID pipeline register.
It honours stall requests from the hazard/bypass control. Branch redirects from EX flush it. A one-entry skid buffer absorbs a fetch that completes while the pipeline is stalled.

Parameters:
PC_WIDTH, 32, width of PC and memory address
INSTR_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset (low 2 bits must be 0)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  PC_WIDTH  fetch address, stable while imem_req=1 and no ack
imem_ack  in  1  request accepted; imem_rdata valid this cycle; may arrive in the same cycle as req
imem_rdata  in  INSTR_WIDTH  fetched instruction
stall  in  1  hold the IF/ID register; from hazard control
flush  in  1  branch taken in EX; redirect to redirect_pc
redirect_pc  in  PC_WIDTH  branch target; bits[1:0] ignored, forced to 0
ifid_instr  out  INSTR_WIDTH  IF/ID instruction
ifid_pc_plus4  out  PC_WIDTH  PC of ifid_instr + 4
ifid_valid  out  1  IF/ID holds a real instruction; 0 = bubble
fetch_busy  out  1  request outstanding without ack this cycle (state RUN & req & !ack, or DRAIN)

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, state=BOOT, skid empty.
  - ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0, imem_req=0.
- imem_req=1 in RUN and DRAIN, 0 in BOOT and FULL.
- imem_addr=pc in RUN; imem_addr=drain_addr in DRAIN.
- Handshake rule: once imem_req=1, the address must not change until the ack cycle.
- Fetch latency: zero-wait memory gives one instruction per clock. An ack at edge N shows in IF/ID after edge N.
- State BOOT: next edge -> RUN. flush/stall are ignored.
- State RUN, priority flush > ack > idle:
  - flush & ack: discard rdata; pc=redirect_pc; stay RUN.
  - flush & !ack: drain_addr=pc; target=redirect_pc; -> DRAIN.
  - ack & !stall: ifid <= {rdata, pc+4}, valid=1; pc=pc+4.
  - ack & stall: skid <= {rdata, pc+4}; pc=pc+4; -> FULL. IF/ID is held.
  - !ack & !stall: ifid_valid<=0 (bubble). !ack & stall: IF/ID held.
- State FULL (no request):
  - flush: skid cleared; pc=redirect_pc; -> RUN.
  - !stall: ifid <= skid, valid=1; -> RUN.
  - stall: hold.
- State DRAIN:
  - ack: discard rdata; pc=target; -> RUN.
  - If flush arrives in the same cycle, the newer redirect_pc wins.
  - flush without ack: target=redirect_pc (latest wins); stay DRAIN.
  - ifid_valid stays 0 while in DRAIN.
- Flush always forces ifid_valid<=0 at the next edge, even if stall=1. Flush overrides stall.
- PC arithmetic: modulo 2^PC_WIDTH; 0xFFFFFFFC+4 wraps to 0x0.
- Reset asserted mid-request: the outstanding request is abandoned. The memory side must tolerate req dropping.

Test Plan:
- Reset then zero-wait stream:
  - Stimulus: ack tied 1, rdata=addr^0xA5A5A5A5.
  - Required: first imem_addr=0x0 one cycle after BOOT.
  - Required: ifid_pc_plus4 = 4, 8, 12… on consecutive cycles, ifid_valid=1.
- Wait states:
  - Stimulus: ack every 3rd cycle.
  - Required: addr holds stable between acks; two bubbles (valid=0) between instructions; fetch_busy=1 while waiting.
- Stall with skid:
  - Stimulus: stall=1 for 3 cycles during a zero-wait stream at pc=0x10.
  - Required: IF/ID holds 0x0C's instruction; 0x10's instruction goes to skid; req=0 in FULL.
  - Required: on release, IF/ID shows 0x10 then 0x14 with no loss or duplicate.
- Flush while request outstanding:
  - Stimulus: ack withheld at addr 0x20; flush with redirect_pc=0x100; ack 2 cycles later.
  - Required: addr stays 0x20 until ack; rdata discarded; next req addr=0x100; ifid_valid=0 throughout.
- Flush and stall same cycle in FULL:
  - Stimulus: redirect_pc=0x203.
  - Required: skid cleared; ifid_valid=0; next fetch addr=0x200.
- Wrap-around:
  - Stimulus: redirect to 0xFFFFFFFC, zero-wait.
  - Required: ifid_pc_plus4=0x00000000; next addr=0x0.
